trace_record_sequencer: RTL and testbench

- Builds one trace_output record per retired-from-decode instruction by timestamping IF, instruction-memory and ID events from the core.
- Sits between the core's pipeline event taps and the trace sink.
- A fetch-tracking FSM fills IF data.
- A small in-flight FIFO holds fetched instructions until ID completes.
- A one-entry output register presents finished records with a valid/ready handshake.

---
 rtl/trace_record_sequencer_pkg.sv | 44 ++++
 rtl/trace_record_sequencer_if.sv | 29 ++
 rtl/trace_record_sequencer_fifo.sv | 42 ++++
 rtl/trace_record_sequencer.sv | 118 +++++++++++
 tb/tb_trace_record_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/trace_record_sequencer_pkg.sv
// trace_record_sequencer_pkg: trace record types, FSM states and widths shared by the sequencer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
package trace_record_sequencer_pkg;
    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int ADDR_WIDTH = `ADDR_WIDTH;
    localparam int TIME_WIDTH = 32;

    typedef logic [TIME_WIDTH-1:0] trace_time_t;
    typedef logic [31:0] trace_int_t;

    typedef struct packed {
        trace_int_t time_start;
        trace_int_t time_end;
    } mem_access_t;

    typedef struct packed {
        trace_int_t time_start;
        trace_int_t time_end;
    } if_data_t;

    typedef struct packed {
        trace_int_t time_start;
        trace_int_t time_end;
    } id_data_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] addr;
        if_data_t              if_data;
        mem_access_t           mem_access;
        id_data_t              id_data;
    } trace_output;

    typedef enum logic [1:0] {IF_IDLE, IF_FETCH, IF_MEM, IF_WAIT} if_state_e;

    function automatic trace_int_t to_int(input trace_time_t t);
        return trace_int_t'(t);
    endfunction
endpackage

// File: rtl/trace_record_sequencer_if.sv
// trace_record_sequencer_if: core pipeline event taps plus the trace sink handshake.
interface trace_record_sequencer_if;
    import trace_record_sequencer_pkg::*;
    logic                  if_start_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  mem_req_i;
    logic                  mem_rvalid_i;
    logic                  if_done_i;
    logic [DATA_WIDTH-1:0] if_instr_i;
    logic                  id_start_i;
    logic                  id_done_i;
    logic                  trace_valid_o;
    logic                  trace_ready_i;
    trace_output           trace_o;
    logic                  fifo_full_o;
    logic                  overflow_o;
    logic                  proto_err_o;

    modport master (
        output if_start_i, if_addr_i, mem_req_i, mem_rvalid_i, if_done_i, if_instr_i,
               id_start_i, id_done_i, trace_ready_i,
        input  trace_valid_o, trace_o, fifo_full_o, overflow_o, proto_err_o
    );
    modport slave (
        input  if_start_i, if_addr_i, mem_req_i, mem_rvalid_i, if_done_i, if_instr_i,
               id_start_i, id_done_i, trace_ready_i,
        output trace_valid_o, trace_o, fifo_full_o, overflow_o, proto_err_o
    );
endinterface

// File: rtl/trace_record_sequencer_fifo.sv
// trace_fifo: synchronous FIFO of trace records with a write port into the head entry's ID start time.
module trace_fifo
    import trace_record_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        start_we_i,
    input  trace_int_t  time_i,
    input  trace_output data_i,
    output trace_output head_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);
    trace_output mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q, count;
    logic wr_en, rd_en;

    assign count   = wr_q - rd_q;
    assign full_o  = count == (AW+1)'(DEPTH);
    assign empty_o = count == '0;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;

    // A full push+pop targets the head slot; the later push assignment wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + (AW+1)'(1);
            if (rd_en) rd_q <= rd_q + (AW+1)'(1);
        end
        if (start_we_i && !empty_o) mem_q[rd_q[AW-1:0]].id_data.time_start <= time_i;
        if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/trace_record_sequencer.sv
// trace_record_sequencer: timestamps IF/mem/ID events into one trace record per decoded instruction.
// Define TRACE_MEM_ACCESS_EN to track instruction-memory request/return times.
module trace_record_sequencer
    import trace_record_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    trace_record_sequencer_if.slave ev
);
    if_state_e   st_q, st_d;
    trace_output cap_q, cap_d, head, rec, out_q;
    trace_time_t now_q;
    trace_int_t  now;
    logic push, if_err, empty, full, avail, id_s, id_d, stall, ovf, valid_q, ovf_q, err_q;

    assign now = to_int(now_q);

    // Same-cycle events chain start -> req -> rvalid -> done.
    always_comb begin
        st_d   = st_q;
        cap_d  = cap_q;
        push   = 1'b0;
        if_err = 1'b0;
        if (ev.if_start_i) begin
            if_err                   = st_q != IF_IDLE;
            cap_d                    = '0;
            cap_d.addr               = ev.if_addr_i;
            cap_d.if_data.time_start = now;
`ifdef TRACE_MEM_ACCESS_EN
            st_d = IF_FETCH;
`else
            st_d = IF_WAIT;
`endif
        end
`ifdef TRACE_MEM_ACCESS_EN
        if (st_d == IF_FETCH && ev.mem_req_i) begin
            cap_d.mem_access.time_start = now;
            st_d                        = IF_MEM;
        end
        if (st_d == IF_MEM && ev.mem_rvalid_i) begin
            cap_d.mem_access.time_end = now;
            st_d                      = IF_WAIT;
        end
`endif
        if (ev.if_done_i) begin
            if (st_d == IF_FETCH) cap_d.mem_access.time_start = now;
            if (st_d inside {IF_FETCH, IF_MEM}) cap_d.mem_access.time_end = now;
            if_err                 = if_err || st_d != IF_WAIT;
            push                   = st_d != IF_IDLE;
            cap_d.instr            = ev.if_instr_i;
            cap_d.if_data.time_end = now;
            st_d                   = IF_IDLE;
        end
    end

`ifndef TRACE_MEM_ACCESS_EN
    logic unused_mem;
    assign unused_mem = ev.mem_req_i ^ ev.mem_rvalid_i;
`endif

    // A push this cycle makes an empty FIFO's incoming record the head for ID events.
    assign avail = !empty || push;
    assign id_s  = ev.id_start_i && avail;
    assign id_d  = ev.id_done_i && avail;
    assign stall = valid_q && !ev.trace_ready_i;
    assign ovf   = (push && full && !id_d) || (id_d && stall);

    always_comb begin
        rec = empty ? cap_d : head;
        if (id_s) rec.id_data.time_start = now;
        if (id_d) rec.id_data.time_end = now;
    end

    trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push && !(empty && id_d)),
        .pop_i      (id_d && !empty),
        .start_we_i (id_s && !empty),
        .time_i     (now),
        .data_i     (empty ? rec : cap_d),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            now_q   <= '0;
            st_q    <= IF_IDLE;
            cap_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            now_q <= now_q + 1'b1;
            st_q  <= st_d;
            cap_q <= cap_d;
            ovf_q <= ovf_q || ovf;
            err_q <= err_q || if_err || ((ev.id_start_i || ev.id_done_i) && !avail);
            if (id_d && !stall) begin
                out_q   <= rec;
                valid_q <= 1'b1;
            end else if (ev.trace_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ev.trace_valid_o = valid_q;
    assign ev.trace_o       = out_q;
    assign ev.fifo_full_o   = full;
    assign ev.overflow_o    = ovf_q;
    assign ev.proto_err_o   = err_q;
endmodule

// File: tb/tb_trace_record_sequencer.sv
// tb_trace_record_sequencer: directed vectors with hand-computed records for trace_record_sequencer.
module tb_trace_record_sequencer;
    import trace_record_sequencer_pkg::*;

`ifdef TRACE_MEM_ACCESS_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int t = 0;

    trace_record_sequencer_if bus ();
    trace_record_sequencer #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .ev(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, act, exp, t);
        end
    endtask

    task automatic clear_pulses();
        bus.if_start_i   = 1'b0;
        bus.mem_req_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.if_done_i    = 1'b0;
        bus.id_start_i   = 1'b0;
        bus.id_done_i    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        clear_pulses();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        clear_pulses();
    endtask

    // Whole fetch in one cycle: legal in both builds.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr);
        bus.if_start_i   = 1'b1;
        bus.mem_req_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.if_done_i    = 1'b1;
        bus.if_addr_i    = addr;
        bus.if_instr_i   = instr;
        step();
    endtask

    function automatic trace_int_t m(input trace_int_t v);
        return MEM_EN ? v : 32'd0;
    endfunction

    function automatic trace_output mk(input logic [31:0] instr, input logic [31:0] addr,
                                       input trace_int_t ifs, input trace_int_t ife,
                                       input trace_int_t ms, input trace_int_t me,
                                       input trace_int_t is, input trace_int_t ie);
        trace_output r;
        r.instr                 = instr;
        r.addr                  = addr;
        r.if_data.time_start    = ifs;
        r.if_data.time_end      = ife;
        r.mem_access.time_start = ms;
        r.mem_access.time_end   = me;
        r.id_data.time_start    = is;
        r.id_data.time_end      = ie;
        return r;
    endfunction

    trace_output rec_a;

    initial begin
        clear_pulses();
        bus.if_addr_i     = '0;
        bus.if_instr_i    = '0;
        bus.trace_ready_i = 1'b1;
        do_reset();
        check("rst_valid", bus.trace_valid_o, 0);
        check("rst_trace", bus.trace_o, 0);
        check("rst_ovf", bus.overflow_o, 0);
        check("rst_err", bus.proto_err_o, 0);
        check("rst_full", bus.fifo_full_o, 0);

        // Basic record with spread-out events
        step();
        step();
        bus.if_start_i = 1'b1;
        bus.if_addr_i  = 32'h80;
        step();
        bus.mem_req_i = 1'b1;
        step();
        step();
        bus.mem_rvalid_i = 1'b1;
        step();
        bus.if_done_i  = 1'b1;
        bus.if_instr_i = 32'h13;
        step();
        bus.id_start_i = 1'b1;
        step();
        step();
        check("t1_pre_valid", bus.trace_valid_o, 0);
        bus.id_done_i = 1'b1;
        step();
        check("t1_valid", bus.trace_valid_o, 1);
        check("t1_rec", bus.trace_o, mk(32'h13, 32'h80, 2, 6, m(3), m(5), 7, 9));
        check("t1_err", bus.proto_err_o, 0);
        step();
        check("t1_drain", bus.trace_valid_o, 0);

        // FIFO fill, overflow on fifth push, in-order drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch(32'h100 + i * 4, 32'h1000 + i);
            if (i == 3) begin
                check("t2_full4", bus.fifo_full_o, 1);
                check("t2_noovf4", bus.overflow_o, 0);
            end
        end
        check("t2_full5", bus.fifo_full_o, 1);
        check("t2_ovf", bus.overflow_o, 1);
        for (int i = 0; i < 4; i++) begin
            bus.id_done_i = 1'b1;
            step();
            check("t2_valid", bus.trace_valid_o, 1);
            check("t2_addr", bus.trace_o.addr, 32'h100 + i * 4);
            if (i == 0) check("t2_notfull", bus.fifo_full_o, 0);
        end
        check("t2_err", bus.proto_err_o, 0);

        // Output stall drops the second record but still pops
        do_reset();
        bus.trace_ready_i = 1'b0;
        fetch(32'h200, 32'hA0);
        fetch(32'h204, 32'hA4);
        bus.id_done_i = 1'b1;
        step();
        rec_a = mk(32'hA0, 32'h200, 0, 0, 0, 0, 0, 2);
        check("t3_valid", bus.trace_valid_o, 1);
        check("t3_rec", bus.trace_o, rec_a);
        check("t3_noovf", bus.overflow_o, 0);
        bus.id_done_i = 1'b1;
        step();
        check("t3_ovf", bus.overflow_o, 1);
        check("t3_hold", bus.trace_o, rec_a);
        check("t3_hold_valid", bus.trace_valid_o, 1);
        step();
        check("t3_hold2", bus.trace_o, rec_a);
        bus.trace_ready_i = 1'b1;
        step();
        check("t3_xfer", bus.trace_valid_o, 0);
        bus.id_done_i = 1'b1;
        step();
        check("t5_empty_valid", bus.trace_valid_o, 0);
        check("t5_empty_err", bus.proto_err_o, 1);

        // Reset in the middle of a fetch
        bus.if_start_i = 1'b1;
        bus.if_addr_i  = 32'h300;
        bus.mem_req_i  = 1'b1;
        step();
        step();
        do_reset();
        check("t5_rst_valid", bus.trace_valid_o, 0);
        check("t5_rst_trace", bus.trace_o, 0);
        check("t5_rst_ovf", bus.overflow_o, 0);
        check("t5_rst_err", bus.proto_err_o, 0);
        check("t5_rst_full", bus.fifo_full_o, 0);
        fetch(32'h400, 32'h44);
        bus.id_done_i = 1'b1;
        step();
        check("t5_restart", bus.trace_o, mk(32'h44, 32'h400, 0, 0, 0, 0, 0, 1));
        check("t5_restart_err", bus.proto_err_o, 0);

        // Same-cycle IF start/done, then same-cycle ID start/done
        do_reset();
        repeat (4) step();
        fetch(32'h40, 32'h33);
        step();
        bus.id_start_i = 1'b1;
        bus.id_done_i  = 1'b1;
        step();
        check("t4_valid", bus.trace_valid_o, 1);
        check("t4_rec", bus.trace_o, mk(32'h33, 32'h40, 4, 4, m(4), m(4), 6, 6));
        check("t4_err", bus.proto_err_o, 0);

        // Fetch and full ID in one cycle bypasses the empty FIFO
        bus.id_start_i = 1'b1;
        bus.id_done_i  = 1'b1;
        fetch(32'h50, 32'h55);
        check("t6_valid", bus.trace_valid_o, 1);
        check("t6_rec", bus.trace_o, mk(32'h55, 32'h50, 7, 7, m(7), m(7), 7, 7));
        check("t6_err", bus.proto_err_o, 0);
        check("t6_ovf", bus.overflow_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
